// File: rtl/ebus_diag_pkg.sv
// ebus_diag_pkg
// Shared types and constants for the EBUS diagnostic master.
//   op_t    : command operation after decode of the 2-bit cmd_op field
//   state_t : sequencer phase encoding
//   DS_*    : diagnostic select codes understood by the CON/CTL decode
//   decode_op   : maps raw cmd_op onto op_t (reserved code 3 becomes CTL)
//   odd_par_err : 1 when data plus parity bit do not carry odd parity
package ebus_diag_pkg;

    typedef enum logic [1:0] {
        OP_CTL   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [6:0] DS_CLR_RUN     = 7'o010;
    localparam logic [6:0] DS_SET_RUN     = 7'o011;
    localparam logic [6:0] DS_CONTINUE    = 7'o012;
    localparam logic [6:0] DS_IR_STROBE   = 7'o014;
    localparam logic [6:0] DS_DRAM_STROBE = 7'o015;
    localparam logic [6:0] DS_READ_13X    = 7'o130;

    function automatic op_t decode_op(input logic [1:0] raw);
        op_t op;
        case (raw)
            2'd1:    op = OP_WRITE;
            2'd2:    op = OP_READ;
            default: op = OP_CTL;
        endcase
        return op;
    endfunction

    // The bus carries odd parity over 36 data bits plus the parity bit,
    // so an even total count of ones is an error.
    function automatic logic odd_par_err(input logic [0:35] data, input logic par);
        return ~((^data) ^ par);
    endfunction

endpackage

// File: rtl/ebus_diag_master.sv
// ebus_diag_master
// Front-end initiator for EBUS diagnostic functions. Takes one command at a
// time, sequences DS setup, DIAG STROBE (CTL/WRITE) or DIAG READ (READ),
// holds DS/data, then reports completion with a one-cycle rsp_valid pulse.
//
// Ports:
//   clk, RESET             : clock, synchronous active-high reset
//   cmd_valid/cmd_ready    : command handshake (taken on valid & ready)
//   cmd_op, cmd_ds, cmd_data : command operation, DS code, write data
//   rsp_valid, rsp_data, rsp_par_err : completion pulse, read data, parity error
//   ebus_ds, ebus_diag_strobe, ebus_diag_read : EBUS diagnostic control lines
//   ebus_data_out, ebus_data_drive : write data and its bus enable
//   ebus_data_in, ebus_parity_in   : bus read data and parity
//
// Build option: define EBUS_DIAG_PARITY_CHK_EN to check odd parity on READ
// capture; otherwise rsp_par_err is always 0 and ebus_parity_in is ignored.
//
// All outputs are registered: the next-state logic also produces next-cycle
// output values, which the state register loads on the same edge.
module ebus_diag_master
    import ebus_diag_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned SETTLE_CYC = 3
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [0:6]  cmd_ds,
    input  logic [0:35] cmd_data,
    output logic        rsp_valid,
    output logic [0:35] rsp_data,
    output logic        rsp_par_err,
    output logic [0:6]  ebus_ds,
    output logic        ebus_diag_strobe,
    output logic        ebus_diag_read,
    output logic [0:35] ebus_data_out,
    output logic        ebus_data_drive,
    input  logic [0:35] ebus_data_in,
    input  logic        ebus_parity_in
);

    localparam int unsigned MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MAX_CD  = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    op_t               op_r, op_nxt_s;
    logic [0:6]        ds_r, ds_nxt_s;
    logic [0:35]       data_r, data_nxt_s;
    logic [0:35]       rd_data_r, rd_data_nxt_s;
    logic              rd_perr_r, rd_perr_nxt_s;
    logic              cap_perr_s;

    logic              ready_nxt_s;
    logic              rsp_valid_nxt_s;
    logic [0:35]       rsp_data_nxt_s;
    logic              rsp_perr_nxt_s;
    logic [0:6]        ebus_ds_nxt_s;
    logic              strobe_nxt_s;
    logic              read_nxt_s;
    logic              drive_nxt_s;
    logic [0:35]       data_out_nxt_s;

`ifdef EBUS_DIAG_PARITY_CHK_EN
    assign cap_perr_s = odd_par_err(ebus_data_in, ebus_parity_in);
`else
    logic unused_parity_s;
    assign unused_parity_s = ebus_parity_in;
    assign cap_perr_s      = 1'b0;
`endif

    // Next-state, phase counter, command capture and next-cycle output decode.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        op_nxt_s       = op_r;
        ds_nxt_s       = ds_r;
        data_nxt_s     = data_r;
        rd_data_nxt_s  = rd_data_r;
        rd_perr_nxt_s  = rd_perr_r;
        rsp_data_nxt_s = rsp_data;
        rsp_perr_nxt_s = rsp_par_err;

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt_s = ST_SETUP;
                    cnt_nxt_s   = SETUP_LD;
                    op_nxt_s    = decode_op(cmd_op);
                    ds_nxt_s    = cmd_ds;
                    data_nxt_s  = cmd_data;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else if (op_r == OP_READ) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = SETTLE_LD;
                end else begin
                    state_nxt_s = ST_STROBE;
                    cnt_nxt_s   = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    state_nxt_s = ST_HOLD;
                    cnt_nxt_s   = HOLD_LD;
                end
            end
            ST_SETTLE: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    // Last settle cycle: bus data has had SETTLE_CYC cycles to settle.
                    state_nxt_s   = ST_HOLD;
                    cnt_nxt_s     = HOLD_LD;
                    rd_data_nxt_s = ebus_data_in;
                    rd_perr_nxt_s = cap_perr_s;
                end
            end
            ST_HOLD: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    // Response fields change only together with rsp_valid.
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = CNT_ZERO;
                    if (op_r == OP_READ) begin
                        rsp_data_nxt_s = rd_data_r;
                        rsp_perr_nxt_s = rd_perr_r;
                    end else begin
                        rsp_data_nxt_s = 36'o0;
                        rsp_perr_nxt_s = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase

        // Output values for the cycle the next state will occupy.
        ready_nxt_s     = (state_nxt_s == ST_IDLE);
        rsp_valid_nxt_s = (state_nxt_s == ST_DONE);
        strobe_nxt_s    = (state_nxt_s == ST_STROBE);
        read_nxt_s      = (state_nxt_s == ST_SETTLE);

        case (state_nxt_s)
            ST_SETUP, ST_STROBE, ST_SETTLE, ST_HOLD: ebus_ds_nxt_s = ds_nxt_s;
            default:                                 ebus_ds_nxt_s = 7'o0;
        endcase

        // A READ never drives, so drive and diag_read are mutually exclusive.
        case (state_nxt_s)
            ST_SETUP, ST_STROBE, ST_HOLD: drive_nxt_s = (op_nxt_s == OP_WRITE);
            default:                      drive_nxt_s = 1'b0;
        endcase

        if (drive_nxt_s) begin
            data_out_nxt_s = data_nxt_s;
        end else begin
            data_out_nxt_s = 36'o0;
        end
    end

    // State, counter, command, capture and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_r          <= ST_IDLE;
            cnt_r            <= CNT_ZERO;
            op_r             <= OP_CTL;
            ds_r             <= 7'o0;
            data_r           <= 36'o0;
            rd_data_r        <= 36'o0;
            rd_perr_r        <= 1'b0;
            cmd_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_data         <= 36'o0;
            rsp_par_err      <= 1'b0;
            ebus_ds          <= 7'o0;
            ebus_diag_strobe <= 1'b0;
            ebus_diag_read   <= 1'b0;
            ebus_data_out    <= 36'o0;
            ebus_data_drive  <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            cnt_r            <= cnt_nxt_s;
            op_r             <= op_nxt_s;
            ds_r             <= ds_nxt_s;
            data_r           <= data_nxt_s;
            rd_data_r        <= rd_data_nxt_s;
            rd_perr_r        <= rd_perr_nxt_s;
            cmd_ready        <= ready_nxt_s;
            rsp_valid        <= rsp_valid_nxt_s;
            rsp_data         <= rsp_data_nxt_s;
            rsp_par_err      <= rsp_perr_nxt_s;
            ebus_ds          <= ebus_ds_nxt_s;
            ebus_diag_strobe <= strobe_nxt_s;
            ebus_diag_read   <= read_nxt_s;
            ebus_data_out    <= data_out_nxt_s;
            ebus_data_drive  <= drive_nxt_s;
        end
    end

endmodule

// File: doc/ebus_diag_master.md
Name: ebus_diag_master

Overview:
- Front-end side initiator for EBUS diagnostic functions. It is the counterpart of the CON/CTL diagnostic decode, which responds to DS codes such as 01x control (CLR RUN, SET RUN, CONTINUE, IR STROBE, DRAM STROBE) and 13x reads.
- Accepts one command at a time from the console/DTE logic.
- Sequences DS setup, DIAG STROBE or DIAG READ, data drive/sample and hold on the EBUS.
- Returns read data and status to the requester.

Parameters:
- SETUP_CYC, 2, cycles DS (and write data) are stable before strobe/read; minimum 1.
- STROBE_CYC, 2, width of DIAG STROBE in cycles; minimum 1.
- HOLD_CYC, 1, cycles DS/data are held after strobe deasserts; minimum 1.
- SETTLE_CYC, 3, cycles DIAG READ is asserted before data is sampled; minimum 1.

Ports:
- clk  in  1  EBOX clock.
- RESET  in  1  synchronous, active-high master reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle, command will be taken.
- cmd_op  in  2  command op: 0 CTL, 1 WRITE, 2 READ, 3 reserved (treated as CTL).
- cmd_ds  in  [0:6]  diagnostic select code.
- cmd_data  in  [0:35]  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  [0:35]  sampled read data (0 for CTL/WRITE).
- rsp_par_err  out  1  read parity mismatch (see Optional Feature).
- ebus_ds  out  [0:6]  DS lines.
- ebus_diag_strobe  out  1  DIAG STROBE.
- ebus_diag_read  out  1  DIAG READ.
- ebus_data_out  out  [0:35]  data to bus.
- ebus_data_drive  out  1  enables ebus_data_out onto the bus.
- ebus_data_in  in  [0:35]  bus data.
- ebus_parity_in  in  1  bus parity bit.

Behaviour:
- Reset values: state IDLE; cmd_ready=1; all other outputs 0.
- RESET is honoured in every state. It aborts mid-operation, drops strobe/read/drive the next cycle and produces no rsp_valid.
- Handshake: the command is taken on a clk edge with cmd_valid & cmd_ready. cmd_ds, cmd_op and cmd_data are registered at that edge, and cmd_ready drops the same edge.
- States:
  - IDLE -> SETUP on accept.
  - SETUP: ebus_ds = registered DS for SETUP_CYC cycles. For WRITE, ebus_data_drive=1 and ebus_data_out = data. Exit to STROBE (CTL/WRITE) or SETTLE (READ).
  - STROBE: ebus_diag_strobe=1 for STROBE_CYC cycles -> HOLD.
  - HOLD: ds/data unchanged, strobe=0, for HOLD_CYC cycles -> DONE.
  - SETTLE: ebus_diag_read=1 for SETTLE_CYC cycles. On the last SETTLE cycle edge, capture ebus_data_in/ebus_parity_in -> HOLD, with diag_read dropping in HOLD.
  - DONE: one cycle with rsp_valid=1. ebus_ds=0, drive=0. cmd_ready=1 in the cycle after DONE, so back-to-back gap is 1 idle cycle.
- Latency, accept to rsp_valid:
  - CTL/WRITE: SETUP_CYC+STROBE_CYC+HOLD_CYC+1.
  - READ: SETUP_CYC+SETTLE_CYC+HOLD_CYC+1.
- Timing invariants:
  - ebus_diag_strobe and ebus_diag_read are never both 1.
  - ebus_data_drive is never 1 while ebus_diag_read is 1.
  - DS never changes while strobe or read is asserted.
- A single down-counter sized by $clog2 of the largest parameter +1 times each phase. It is loaded with phase length -1 on phase entry and exits at 0.
- rsp_data/rsp_par_err hold their values until the next rsp_valid. They are 0 after reset.
- cmd_valid during busy is ignored; no queueing.

Optional Feature:
- Macro EBUS_DIAG_PARITY_CHK_EN.
- Defined: at the READ capture edge, rsp_par_err = (^captured_data) XNOR ebus_parity_in, i.e. the bus carries odd parity across the 37 bits. CTL/WRITE report 0.
- Undefined: rsp_par_err is tied 0 and ebus_parity_in is unused.

Decomposition:
- Shared package ebus_diag_pkg:
  - typedef enum op_t {OP_CTL, OP_WRITE, OP_READ}.
  - typedef state_t.
  - DS constants:
    - DS_CLR_RUN=7'o010
    - DS_SET_RUN=7'o011
    - DS_CONTINUE=7'o012
    - DS_IR_STROBE=7'o014
    - DS_DRAM_STROBE=7'o015
    - DS_READ_13x base 7'o130
- No sub-module. The phase counter stays inline.

Test Plan:
- Default params, reset, CTL DS_CONTINUE -> ds=7'o012 from cycle 1. Strobe high in cycles 3-4 after accept, rsp_valid at cycle 6, rsp_data=0.
- WRITE ds=7'o020 data=36'o123456701234 -> drive=1 and data stable from SETUP through HOLD. Strobe 2 cycles, rsp_valid at cycle 6.
- READ ds=7'o131, bench drives ebus_data_in=36'o777000111222 during SETTLE -> diag_read cycles 3-5, strobe never 1, rsp_data=36'o777000111222 at cycle 7.
- Back-to-back: cmd_valid held with SET_RUN then CLR_RUN -> second accept exactly 1 cycle after first rsp_valid, and no DS change during strobe.
- RESET asserted in the second STROBE cycle -> next cycle strobe=0, ds=0, cmd_ready=1, and no rsp_valid.
- With EBUS_DIAG_PARITY_CHK_EN: READ data 36'o1 with parity_in 0 -> rsp_par_err=0. Parity_in 1 -> rsp_par_err=1. Without the macro -> rsp_par_err=0 in both cases.
